gpio_irq: RTL and testbench

- Parametrised successor to the fixed 8-pin GPIO block. Provides N_GPIO pads with the following, all from an APB slave on clk:
  - SIO-style output and output-enable registers, each with write/XOR/SET/CLR aliases.
  - Per-pin function select to an alternate peripheral.
  - 2-flop input synchronisers.
  - Per-pin edge and level interrupt detection, combined into a single registered interrupt line to the processor's interrupt controller.
- Sits between the APB fabric and the pad ring.

---
 rtl/gpio_irq_pkg.sv | 44 ++++
 rtl/gpio_irq_pin.sv | 103 ++++++++++
 rtl/gpio_irq.sv | 176 +++++++++++++++++
 tb/tb_gpio_irq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - shared register map and alias-update helper for gpio_irq
package gpio_irq_pkg;

    // Byte offsets of the register map; only paddr[5:2] is decoded.
    localparam logic [5:0] GPIO_OFFS_OUT         = 6'h00;
    localparam logic [5:0] GPIO_OFFS_OUT_XOR     = 6'h04;
    localparam logic [5:0] GPIO_OFFS_OUT_SET     = 6'h08;
    localparam logic [5:0] GPIO_OFFS_OUT_CLR     = 6'h0C;
    localparam logic [5:0] GPIO_OFFS_OE          = 6'h10;
    localparam logic [5:0] GPIO_OFFS_OE_XOR      = 6'h14;
    localparam logic [5:0] GPIO_OFFS_OE_SET      = 6'h18;
    localparam logic [5:0] GPIO_OFFS_OE_CLR      = 6'h1C;
    localparam logic [5:0] GPIO_OFFS_IN          = 6'h20;
    localparam logic [5:0] GPIO_OFFS_FSEL        = 6'h24;
    localparam logic [5:0] GPIO_OFFS_IRQ_RISE_EN = 6'h28;
    localparam logic [5:0] GPIO_OFFS_IRQ_FALL_EN = 6'h2C;
    localparam logic [5:0] GPIO_OFFS_IRQ_HIGH_EN = 6'h30;
    localparam logic [5:0] GPIO_OFFS_IRQ_LOW_EN  = 6'h34;
    localparam logic [5:0] GPIO_OFFS_IRQ_STAT    = 6'h38;
    localparam logic [5:0] GPIO_OFFS_IRQ_PEND    = 6'h3C;

    // Encoding matches paddr[3:2] within the OUT and OE alias groups.
    typedef enum logic [1:0] {
        ALIAS_WRITE = 2'd0,
        ALIAS_XOR   = 2'd1,
        ALIAS_SET   = 2'd2,
        ALIAS_CLR   = 2'd3
    } alias_op_e;

    function automatic logic [31:0] alias_apply(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input alias_op_e   op);
        logic [31:0] res;
        case (op)
            ALIAS_WRITE: res = wd;
            ALIAS_XOR:   res = cur ^ wd;
            ALIAS_SET:   res = cur | wd;
            ALIAS_CLR:   res = cur & ~wd;
            default:     res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gpio_irq_pin.sv
// rtl/gpio_irq_pin.sv - per-pin synchroniser, optional glitch filter, edge detect and STAT flag
//
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN (glitch filter between sync and edge detect).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pad_i           raw pad input
//   rise_en_i       rising-edge interrupt enable
//   fall_en_i       falling-edge interrupt enable
//   stat_clr_i      write-1-to-clear strobe for the edge flag
//   in_o            synchronised (and filtered) input level
//   stat_o          latched edge flag
module gpio_irq_pin #(
    parameter int DEBOUNCE_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic stat_clr_i,
    output logic in_o,
    output logic stat_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic stat_q;
    logic stat_d;
    logic filt;
    logic rise;
    logic fall;
    logic edge_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // Filtered value flips on the last of 2^W-1 consecutive disagreeing samples.
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'((2 ** DEBOUNCE_W) - 2);

    logic                  filt_q;
    logic                  filt_d;
    logic [DEBOUNCE_W-1:0] cnt_q;
    logic [DEBOUNCE_W-1:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + DEBOUNCE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    localparam int unused_debounce_w = DEBOUNCE_W;
    assign filt = sync2_q;
`endif

    assign rise     = filt & ~prev_q;
    assign fall     = ~filt & prev_q;
    assign edge_set = (rise & rise_en_i) | (fall & fall_en_i);

    // A new qualifying edge beats a simultaneous write-1-to-clear.
    assign stat_d = edge_set | (stat_q & ~stat_clr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            stat_q <= 1'b0;
        end else begin
            prev_q <= filt;
            stat_q <= stat_d;
        end
    end

    assign in_o   = filt;
    assign stat_o = stat_q;

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - APB GPIO block with output aliases, function select and edge/level interrupts
//
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN (per-pin glitch filter, DEBOUNCE_W counter).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   apbs_psel/penable/pwrite         APB control
//   apbs_paddr[15:0], apbs_pwdata    APB address (bits [5:2] decoded) and write data
//   apbs_prdata, apbs_pready         read data (0 when unselected), always ready
//   apbs_pslverr                     error for paddr[15:6] != 0
//   alt_out / alt_in                 alternate-function output values / raw pad input
//   padout_gpio, padoe_gpio          pad output value and enable
//   padin_gpio                       pad input
//   irq                              registered interrupt request
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int                N_GPIO      = 8,
    parameter logic [N_GPIO-1:0] ALT_OE_MASK = '0,
    parameter int                DEBOUNCE_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apbs_psel,
    input  logic              apbs_penable,
    input  logic              apbs_pwrite,
    input  logic [15:0]       apbs_paddr,
    input  logic [31:0]       apbs_pwdata,
    output logic [31:0]       apbs_prdata,
    output logic              apbs_pready,
    output logic              apbs_pslverr,
    input  logic [N_GPIO-1:0] alt_out,
    output logic [N_GPIO-1:0] alt_in,
    output logic [N_GPIO-1:0] padout_gpio,
    output logic [N_GPIO-1:0] padoe_gpio,
    input  logic [N_GPIO-1:0] padin_gpio,
    output logic              irq
);

    logic              access;
    logic              addr_err;
    logic              wr_en;
    logic [3:0]        word;
    logic [5:0]        offs;
    alias_op_e         op;

    logic [N_GPIO-1:0] out_q,     out_d;
    logic [N_GPIO-1:0] oe_q,      oe_d;
    logic [N_GPIO-1:0] fsel_q,    fsel_d;
    logic [N_GPIO-1:0] rise_en_q, rise_en_d;
    logic [N_GPIO-1:0] fall_en_q, fall_en_d;
    logic [N_GPIO-1:0] high_en_q, high_en_d;
    logic [N_GPIO-1:0] low_en_q,  low_en_d;
    logic              irq_q,     irq_d;

    logic [N_GPIO-1:0] stat_clr;
    logic [N_GPIO-1:0] pin_in;
    logic [N_GPIO-1:0] stat;
    logic [N_GPIO-1:0] pend;
    logic [31:0]       out_upd;
    logic [31:0]       oe_upd;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign word     = apbs_paddr[5:2];
    assign offs     = {word, 2'b00};
    assign op       = alias_op_e'(word[1:0]);
    assign addr_err = |apbs_paddr[15:6];
    assign access   = apbs_psel & apbs_penable;
    assign wr_en    = access & apbs_pwrite & ~addr_err;

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = access & addr_err;

    assign out_upd = alias_apply(32'(out_q), apbs_pwdata, op);
    assign oe_upd  = alias_apply(32'(oe_q), apbs_pwdata, op);

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        fsel_d    = fsel_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        high_en_d = high_en_q;
        low_en_d  = low_en_q;
        stat_clr  = '0;
        if (wr_en) begin
            case (offs)
                GPIO_OFFS_OUT, GPIO_OFFS_OUT_XOR,
                GPIO_OFFS_OUT_SET, GPIO_OFFS_OUT_CLR: out_d = out_upd[N_GPIO-1:0];
                GPIO_OFFS_OE, GPIO_OFFS_OE_XOR,
                GPIO_OFFS_OE_SET, GPIO_OFFS_OE_CLR:   oe_d = oe_upd[N_GPIO-1:0];
                GPIO_OFFS_FSEL:        fsel_d    = apbs_pwdata[N_GPIO-1:0];
                GPIO_OFFS_IRQ_RISE_EN: rise_en_d = apbs_pwdata[N_GPIO-1:0];
                GPIO_OFFS_IRQ_FALL_EN: fall_en_d = apbs_pwdata[N_GPIO-1:0];
                GPIO_OFFS_IRQ_HIGH_EN: high_en_d = apbs_pwdata[N_GPIO-1:0];
                GPIO_OFFS_IRQ_LOW_EN:  low_en_d  = apbs_pwdata[N_GPIO-1:0];
                GPIO_OFFS_IRQ_STAT:    stat_clr  = apbs_pwdata[N_GPIO-1:0];
                default: ;
            endcase
        end
    end

    // Level sources are unlatched; edge flags only count while their enable is set.
    assign pend  = (stat & (rise_en_q | fall_en_q))
                 | (pin_in & high_en_q)
                 | (~pin_in & low_en_q);
    assign irq_d = |pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            oe_q      <= '0;
            fsel_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            high_en_q <= '0;
            low_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            fsel_q    <= fsel_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            high_en_q <= high_en_d;
            low_en_q  <= low_en_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (apbs_psel && !addr_err) begin
            case (offs)
                GPIO_OFFS_OUT, GPIO_OFFS_OUT_XOR,
                GPIO_OFFS_OUT_SET, GPIO_OFFS_OUT_CLR: rdata = 32'(out_q);
                GPIO_OFFS_OE, GPIO_OFFS_OE_XOR,
                GPIO_OFFS_OE_SET, GPIO_OFFS_OE_CLR:   rdata = 32'(oe_q);
                GPIO_OFFS_IN:          rdata = 32'(pin_in);
                GPIO_OFFS_FSEL:        rdata = 32'(fsel_q);
                GPIO_OFFS_IRQ_RISE_EN: rdata = 32'(rise_en_q);
                GPIO_OFFS_IRQ_FALL_EN: rdata = 32'(fall_en_q);
                GPIO_OFFS_IRQ_HIGH_EN: rdata = 32'(high_en_q);
                GPIO_OFFS_IRQ_LOW_EN:  rdata = 32'(low_en_q);
                GPIO_OFFS_IRQ_STAT:    rdata = 32'(stat);
                GPIO_OFFS_IRQ_PEND:    rdata = 32'(pend);
                default:               rdata = '0;
            endcase
        end
    end

    assign apbs_prdata = rdata;

    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        gpio_irq_pin #(
            .DEBOUNCE_W (DEBOUNCE_W)
        ) u_pin (
            .clk        (clk),
            .rst_n      (rst_n),
            .pad_i      (padin_gpio[i]),
            .rise_en_i  (rise_en_q[i]),
            .fall_en_i  (fall_en_q[i]),
            .stat_clr_i (stat_clr[i]),
            .in_o       (pin_in[i]),
            .stat_o     (stat[i])
        );
    end

    assign padout_gpio = (fsel_q & alt_out) | (~fsel_q & out_q);
    assign padoe_gpio  = (fsel_q & ALT_OE_MASK) | (~fsel_q & oe_q);
    assign alt_in      = padin_gpio;
    assign irq         = irq_q;

    assign unused_ok = ^{apbs_paddr[1:0], out_upd, oe_upd};

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - randomized and directed bench for gpio_irq against a behavioural model
module tb_gpio_irq;

    localparam int         N      = 8;
    localparam logic [7:0] ALT_M  = 8'h01;
    localparam int         DB_W   = 2;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int         DB_MAX = (2 ** DB_W) - 1;
    localparam int         LAT    = 4 + DB_MAX;
`else
    localparam int         LAT    = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  alt_out = '0;
    logic [7:0]  alt_in, padout, padoe;
    logic [7:0]  padin = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_irq #(.N_GPIO(N), .ALT_OE_MASK(ALT_M), .DEBOUNCE_W(DB_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_psel    (psel),
        .apbs_penable (penable),
        .apbs_pwrite  (pwrite),
        .apbs_paddr   (paddr),
        .apbs_pwdata  (pwdata),
        .apbs_prdata  (prdata),
        .apbs_pready  (pready),
        .apbs_pslverr (pslverr),
        .alt_out      (alt_out),
        .alt_in       (alt_in),
        .padout_gpio  (padout),
        .padoe_gpio   (padoe),
        .padin_gpio   (padin),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: registers, edge flags, and a history of pad samples.
    logic [7:0]  m_out, m_oe, m_fsel, m_rise, m_fall, m_high, m_low, m_stat;
    logic        m_irq;
    logic [7:0]  s0, s1;          // pad sampled one and two edges ago
    logic [7:0]  f_cur, f_prev;   // visible input level now and one edge ago
    int          run [8];
    logic        pw_valid = 1'b0;
    logic [15:0] pw_addr;
    logic [31:0] pw_data;
    logic [31:0] rdat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_oe = '0; m_fsel = '0; m_rise = '0; m_fall = '0;
        m_high = '0; m_low = '0; m_stat = '0; m_irq = 1'b0;
        s0 = '0; s1 = '0; f_cur = '0; f_prev = '0;
        for (int i = 0; i < 8; i++) run[i] = 0;
    endtask

    function automatic logic [7:0] m_pend();
        return (m_stat & (m_rise | m_fall)) | (f_cur & m_high) | (~f_cur & m_low);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (a[15:6] != 0) return 32'h0;
        case (a[5:2])
            4'd0, 4'd1, 4'd2, 4'd3:     return {24'h0, m_out};
            4'd4, 4'd5, 4'd6, 4'd7:     return {24'h0, m_oe};
            4'd8:  return {24'h0, f_cur};
            4'd9:  return {24'h0, m_fsel};
            4'd10: return {24'h0, m_rise};
            4'd11: return {24'h0, m_fall};
            4'd12: return {24'h0, m_high};
            4'd13: return {24'h0, m_low};
            4'd14: return {24'h0, m_stat};
            default: return {24'h0, m_pend()};
        endcase
    endfunction

    task automatic apply_write(input logic [15:0] a, input logic [31:0] d, output logic [7:0] clr);
        clr = '0;
        if (a[15:6] == 0) begin
            case (a[5:2])
                4'd0: m_out = d[7:0];
                4'd1: m_out = m_out ^ d[7:0];
                4'd2: m_out = m_out | d[7:0];
                4'd3: m_out = m_out & ~d[7:0];
                4'd4: m_oe = d[7:0];
                4'd5: m_oe = m_oe ^ d[7:0];
                4'd6: m_oe = m_oe | d[7:0];
                4'd7: m_oe = m_oe & ~d[7:0];
                4'd9:  m_fsel = d[7:0];
                4'd10: m_rise = d[7:0];
                4'd11: m_fall = d[7:0];
                4'd12: m_high = d[7:0];
                4'd13: m_low  = d[7:0];
                4'd14: clr = d[7:0];
                default: ;
            endcase
        end
    endtask

    // One clock edge: advance the model, then compare pad outputs and irq.
    task automatic tick();
        logic [7:0] old_pend, set, clr, fnew;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            old_pend = m_pend();
            set = ((f_cur & ~f_prev) & m_rise) | ((~f_cur & f_prev) & m_fall);
            clr = '0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
            fnew = f_cur;
            for (int i = 0; i < 8; i++) begin
                if (s1[i] == f_cur[i]) run[i] = 0;
                else begin
                    run[i]++;
                    if (run[i] == DB_MAX) begin
                        fnew[i] = s1[i];
                        run[i] = 0;
                    end
                end
            end
`else
            fnew = s0;
`endif
            if (pw_valid) apply_write(pw_addr, pw_data, clr);
            m_stat = set | (m_stat & ~clr);
            m_irq  = |old_pend;
            f_prev = f_cur;
            f_cur  = fnew;
            s1 = s0;
            s0 = padin;
        end
        #1;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("padout", {24'd0, padout}, {24'd0, (m_fsel & alt_out) | (~m_fsel & m_out)});
        chk("padoe", {24'd0, padoe}, {24'd0, (m_fsel & ALT_M) | (~m_fsel & m_oe)});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        tick();
        penable = 1'b1; pw_valid = 1'b1; pw_addr = a; pw_data = d;
        tick();
        pw_valid = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        tick();
        penable = 1'b1;
        @(negedge clk);
        rdat = prdata;
        chk(tag, prdata, model_read(a));
        chk({tag, "_err"}, {31'd0, pslverr}, {31'd0, (a[15:6] != 0)});
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [3:0]  w;
        logic [15:0] a;
        int          n;
        model_reset();

        // Reset state
        ticks(2);
        rst_n = 1'b1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_padoe", {24'd0, padoe}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_chk("rst_read", 16'(i * 4));
            chk("rst_zero", rdat, 32'd0);
        end
        rd_chk("bad_addr", 16'h0040);
        chk("bad_addr_data", rdat, 32'd0);

        // OUT aliases and OE
        apb_write(16'h00, 32'hA5);
        apb_write(16'h04, 32'h0F);
        rd_chk("out_xor", 16'h00);   chk("out_aa", rdat, 32'hAA);
        rd_chk("alias_rd", 16'h0C);  chk("alias_aa", rdat, 32'hAA);
        apb_write(16'h08, 32'h10);
        rd_chk("out_set", 16'h00);   chk("out_ba", rdat, 32'hBA);
        apb_write(16'h0C, 32'h80);
        rd_chk("out_clr", 16'h00);   chk("out_3a", rdat, 32'h3A);
        chk("padout_3a", {24'd0, padout}, 32'h3A);
        apb_write(16'h10, 32'hFF);
        chk("padoe_ff", {24'd0, padoe}, 32'hFF);
        apb_write(16'h40, 32'hFF);   // unmapped write is ignored

        // Alternate function on pin 0 with OE[0] cleared
        apb_write(16'h1C, 32'h01);
        apb_write(16'h24, 32'h01);
        for (int i = 0; i < 4; i++) begin
            alt_out = 8'(i[0] ? 8'hFF : 8'h00) ^ 8'($urandom);
            tick();
            chk("alt_pad0", {31'd0, padout[0]}, {31'd0, alt_out[0]});
            chk("alt_oe0", {31'd0, padoe[0]}, 32'd1);
        end

        // Rising edge on pin 2: STAT after 3 edges, irq one edge later
        apb_write(16'h28, 32'h04);
        padin[2] = 1'b1;
        ticks(2);
        chk("rise_irq_early", {31'd0, irq}, 32'd0);
        rd_chk("rise_stat", 16'h38);
        chk("rise_stat_04", rdat, 32'h04);
        chk("rise_irq", {31'd0, irq}, 32'd1);
        apb_write(16'h38, 32'h04);
        rd_chk("w1c_stat", 16'h38);  chk("w1c_00", rdat, 32'h00);
        padin[2] = 1'b0;
        ticks(LAT + 2);
        padin[2] = 1'b1;
        tick();
        apb_write(16'h38, 32'h04);   // clear lands on the same edge as the set
        rd_chk("set_wins", 16'h38);  chk("set_wins_04", rdat, 32'h04);
        apb_write(16'h38, 32'hFF);
        apb_write(16'h28, 32'h00);

        // High level on pin 1
        apb_write(16'h30, 32'h02);
        padin[1] = 1'b1;
        ticks(LAT);
        rd_chk("lvl_pend", 16'h3C);  chk("lvl_pend_02", rdat, 32'h02);
        chk("lvl_irq", {31'd0, irq}, 32'd1);
        padin[1] = 1'b0;
        n = 0;
        while (irq !== 1'b0 && n < LAT + 4) begin
            tick();
            n++;
        end
        chk("lvl_drop", {31'd0, (n <= LAT)}, 32'd1);
        rd_chk("lvl_stat", 16'h38);  chk("lvl_stat_00", rdat, 32'h00);
        apb_write(16'h30, 32'h00);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0: begin padin = 8'($urandom); ticks($urandom_range(1, 4)); end
                1: begin
                    w = 4'($urandom_range(10, 14));
                    apb_write({10'd0, w, 2'b00}, $urandom);
                end
                2: begin
                    w = 4'($urandom_range(0, 9));
                    if (w == 4'd8) w = 4'd0;
                    apb_write({10'd0, w, 2'b00}, $urandom);
                end
                3: begin
                    w = 4'($urandom_range(0, 15));
                    a = {10'd0, w, 2'b00};
                    if ($urandom_range(0, 7) == 0) a[6 + $urandom_range(0, 9)] = 1'b1;
                    rd_chk("rnd_read", a);
                end
                default: begin alt_out = 8'($urandom); tick(); end
            endcase
        end

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // Glitch filter on pin 0
        for (int r = 10; r < 14; r++) apb_write(16'(r * 4), 32'h0);
        apb_write(16'h2C, 32'h01);
        padin[0] = 1'b1;
        ticks(12);
        apb_write(16'h38, 32'hFF);
        padin[0] = 1'b0;
        ticks(2);
        padin[0] = 1'b1;
        ticks(12);
        rd_chk("glitch_stat", 16'h38);  chk("glitch_bit0", {31'd0, rdat[0]}, 32'd0);
        padin[0] = 1'b0;
        ticks(5);
        padin[0] = 1'b1;
        ticks(12);
        rd_chk("pulse_stat", 16'h38);   chk("pulse_bit0", {31'd0, rdat[0]}, 32'd1);
`endif

        // Asynchronous reset mid-operation
        apb_write(16'h00, 32'h5A);
        apb_write(16'h10, 32'hF0);
        apb_write(16'h30, 32'hFF);
        padin = 8'hFF;
        ticks(LAT);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("arst_padoe", {24'd0, padoe}, 32'd0);
        chk("arst_padout", {24'd0, padout}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        tick();
        rst_n = 1'b1;
        rd_chk("arst_out", 16'h00);     chk("arst_out_00", rdat, 32'h00);
        rd_chk("arst_stat", 16'h38);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
